fifo_write_arbiter: RTL

- Round-robin arbiter that shares the single write port of a FIFO among N_REQ requesters.
- Grants one requester at a time for a burst. The burst ends on the requester's last flag, at MAX_BURST beats, or when the requester drops its request.
- Drives the FIFO write strobe and data. Stalls on the FIFO full flag.
- Sits directly in front of the FIFO write side. The FIFO read side is untouched.

---
 rtl/fifo_pkg.sv | 11 +
 rtl/rr_pick.sv | 38 +++
 rtl/fifo_write_arbiter.sv | 105 ++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared types and helpers for the FIFO write-side arbiter.
package fifo_pkg;

  typedef enum logic {IDLE, BURST} arb_state_t;

  // Wrap-around increment: idx+1, or 0 once idx reaches n-1 (any n, not just powers of 2).
  function automatic int next_idx(input int idx, input int n);
    return (idx == n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set bit of req, searching upward from rr_ptr with wrap.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int IW    = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    rr_ptr,
  output logic             found,
  output logic [IW-1:0]    idx
);

  logic [2*N_REQ-1:0] dbl;
  logic [N_REQ-1:0]   rot;
  logic [IW-1:0]      off;
  logic [IW:0]        sum;

  // Rotate so rr_ptr lands at bit 0; the doubled vector makes any N_REQ wrap cleanly.
  always_comb begin
    dbl = {req, req} >> rr_ptr;
    rot = dbl[N_REQ-1:0];
  end

  // Priority-encode the rotated vector (lowest bit wins), then un-rotate the offset.
  always_comb begin
    found = 1'b0;
    off   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        found = 1'b1;
        off   = IW'(k);
      end
    end
    sum = {1'b0, rr_ptr} + {1'b0, off};
    if (sum >= (IW+1)'(N_REQ)) sum = sum - (IW+1)'(N_REQ);
    idx = sum[IW-1:0];
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port among N_REQ requesters.
module fifo_write_arbiter
  import fifo_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4,
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1,
  localparam int BW = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ-1:0]       last,
  input  logic [N_REQ*WIDTH-1:0] wdata_in,
  input  logic                   full,
  output logic [N_REQ-1:0]       gnt,
  output logic                   fifo_write,
  output logic [WIDTH-1:0]       fifo_wdata,
  output logic                   busy,
  output logic [IW-1:0]          owner
);

  arb_state_t    state_q, state_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [IW-1:0] rr_q, rr_d;
  logic [BW-1:0] beat_q, beat_d;

  logic          found;
  logic [IW-1:0] pick;
  logic          accept;
  logic          last_beat;

  logic [WIDTH-1:0] words [N_REQ];

  for (genvar i = 0; i < N_REQ; i++) begin : g_words
    assign words[i] = wdata_in[i*WIDTH +: WIDTH];
  end

  rr_pick #(.N_REQ(N_REQ), .IW(IW)) u_pick (
    .req    (req),
    .rr_ptr (rr_q),
    .found  (found),
    .idx    (pick)
  );

  // Beat acceptance; gated by reset so nothing is written in a reset cycle.
  always_comb begin
    accept    = reset && (state_q == BURST) && req[owner_q] && !full;
    last_beat = last[owner_q] || (beat_q == BW'(MAX_BURST - 1));
  end

  // Next-state: arbitrate in IDLE, count beats and detect release in BURST.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    beat_d  = beat_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          owner_d = pick;
          state_d = BURST;
          beat_d  = '0;
        end
      end
      BURST: begin
        if ((accept && last_beat) || !req[owner_q]) begin
          state_d = IDLE;
          rr_d    = IW'(next_idx(int'(owner_q), N_REQ));
          beat_d  = '0;
        end else if (accept) begin
          beat_d  = beat_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      owner_q <= '0;
      rr_q    <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      beat_q  <= beat_d;
    end
  end

  // Write-side outputs follow the accept strobe combinationally.
  always_comb begin
    gnt = '0;
    if (accept) gnt[owner_q] = 1'b1;
    fifo_write = accept;
    fifo_wdata = accept ? words[owner_q] : '0;
    busy       = (state_q == BURST);
    owner      = busy ? owner_q : '0;
  end

endmodule
